// File: rtl/nabp_pkg.sv
// Shared constants, FSM state type and fixed-point sizing helpers for the NABP mapper datapath.
package nabp_pkg;

   localparam int ANGLE_W     = 8;
   localparam int ACCU_INT_W  = 9;
   localparam int ACCU_FRAC_W = 12;
   localparam int IMAGE_SIZE  = 128;
   localparam int LINE_LEN    = 128;
   localparam int ADDR_W      = 7;

   typedef enum logic [2:0] {
      IDLE,
      WAIT1,
      WAIT2,
      LOAD,
      RUN,
      DONE
   } mapper_state_t;

   // Sign bit + integer bits + fractional bits.
   function automatic int accu_width(input int int_w, input int frac_w);
      return 1 + int_w + frac_w;
   endfunction

   function automatic int step_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/nabp_mapper_addr_gen_if.sv
// Line-buffer address stream: valid/ready with out-of-bounds and last-step side flags.
interface nabp_mapper_addr_gen_if #(
   parameter int ADDR_W = nabp_pkg::ADDR_W
);

   logic              addr_valid;
   logic              addr_ready;
   logic [ADDR_W-1:0] addr;
   logic              addr_oob;
   logic              addr_last;

   modport master (
      output addr_valid,
      input  addr_ready,
      output addr,
      output addr_oob,
      output addr_last
   );

   modport slave (
      input  addr_valid,
      output addr_ready,
      input  addr,
      input  addr_oob,
      input  addr_last
   );

endinterface

// File: rtl/nabp_fixed_floor_oob.sv
// Signed fixed-point accumulator to line-buffer address: floor toward -inf, with out-of-range flag.
module nabp_fixed_floor_oob
   import nabp_pkg::*;
#(
   parameter int INT_W    = ACCU_INT_W,
   parameter int FRAC_W   = ACCU_FRAC_W,
   parameter int LINE_LEN = nabp_pkg::LINE_LEN,
   parameter int ADDR_W   = nabp_pkg::ADDR_W,
   localparam int ACCU_W  = accu_width(INT_W, FRAC_W)
) (
   input  logic signed [ACCU_W-1:0] accu,
   output logic [ADDR_W-1:0]        addr,
   output logic                     oob
);

   // Dropping the fraction bits of a two's-complement value is already floor toward -inf.
   logic signed [INT_W:0] int_part;
   logic                  too_high;
   logic                  unused_frac;

   assign int_part    = accu[ACCU_W-1:FRAC_W];
   assign unused_frac = ^accu[FRAC_W-1:0];
   assign too_high    = ({1'b0, int_part[INT_W-1:0]} >= (INT_W+1)'(LINE_LEN));
   assign oob         = int_part[INT_W] | too_high;
   assign addr        = oob ? '0 : int_part[ADDR_W-1:0];

endmodule

// File: rtl/nabp_mapper_addr_gen.sv
// Per-angle address generator: primes the coefficient LUT, then streams floor(base + k*part) for IMAGE_SIZE steps.
module nabp_mapper_addr_gen #(
   parameter int  ANGLE_W     = nabp_pkg::ANGLE_W,
   parameter int  ACCU_INT_W  = nabp_pkg::ACCU_INT_W,
   parameter int  ACCU_FRAC_W = nabp_pkg::ACCU_FRAC_W,
   parameter int  IMAGE_SIZE  = nabp_pkg::IMAGE_SIZE,
   parameter int  LINE_LEN    = nabp_pkg::LINE_LEN,
   parameter int  ADDR_W      = nabp_pkg::ADDR_W,
   localparam int ACCU_W      = 1 + ACCU_INT_W + ACCU_FRAC_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [ANGLE_W-1:0]       angle,
   output logic                     busy,
   output logic                     done,
   output logic [ANGLE_W-1:0]       mp_angle,
   input  logic signed [ACCU_W-1:0] mp_accu_part,
   input  logic signed [ACCU_W-1:0] mp_accu_base,
   nabp_mapper_addr_gen_if.master   addr_bus
);

   import nabp_pkg::*;

   localparam int               STEP_W    = step_width(IMAGE_SIZE);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(IMAGE_SIZE - 1);

   mapper_state_t            state_reg;
   mapper_state_t            state_next;
   logic [ANGLE_W-1:0]       angle_reg;
   logic signed [ACCU_W-1:0] accu_reg;
   logic signed [ACCU_W-1:0] accu_sum;
   logic [STEP_W-1:0]        step_reg;
   logic                     run;
   logic                     at_last;
   logic                     xfer;
   logic                     sum_ovf;
   logic [ADDR_W-1:0]        floor_addr;
   logic                     floor_oob;

   assign run     = (state_reg == RUN);
   assign at_last = (step_reg == LAST_STEP);
   assign xfer    = run && addr_bus.addr_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // WAIT1/WAIT2 absorb the LUT's two register stages so base/part are valid in LOAD.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (start) state_next = WAIT1;
         WAIT1:   state_next = WAIT2;
         WAIT2:   state_next = LOAD;
         LOAD:    state_next = RUN;
         RUN:     if (xfer && at_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign accu_sum = accu_reg + mp_accu_part;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         angle_reg <= '0;
         accu_reg  <= '0;
         step_reg  <= '0;
      end else begin
         if (state_reg == IDLE && start) begin
            angle_reg <= angle;
         end
         if (state_reg == LOAD) begin
            accu_reg <= mp_accu_base;
            step_reg <= '0;
         end else if (xfer) begin
            accu_reg <= accu_sum;
            step_reg <= step_reg + STEP_W'(1);
         end
      end
   end

   nabp_fixed_floor_oob #(
      .INT_W    (ACCU_INT_W),
      .FRAC_W   (ACCU_FRAC_W),
      .LINE_LEN (LINE_LEN),
      .ADDR_W   (ADDR_W)
   ) u_floor_oob (
      .accu (accu_reg),
      .addr (floor_addr),
      .oob  (floor_oob)
   );

   assign busy                = (state_reg != IDLE);
   assign done                = (state_reg == DONE);
   assign mp_angle            = angle_reg;
   assign addr_bus.addr_valid = run;
   assign addr_bus.addr       = run ? floor_addr : '0;
   assign addr_bus.addr_oob   = run && floor_oob;
   assign addr_bus.addr_last  = run && at_last;

   // Same-sign operands producing an opposite-sign sum means the accumulator wrapped.
   assign sum_ovf = (accu_reg[ACCU_W-1] == mp_accu_part[ACCU_W-1]) &&
                    (accu_sum[ACCU_W-1] != accu_reg[ACCU_W-1]);

   a_no_accu_wrap : assert property (@(posedge clk) disable iff (!reset_n) xfer |-> !sum_ovf);

   a_stall_holds_addr : assert property (@(posedge clk) disable iff (!reset_n)
      (run && !addr_bus.addr_ready) |=> (run && $stable(addr_bus.addr) &&
                                         $stable(addr_bus.addr_oob) && $stable(addr_bus.addr_last)));

endmodule

// File: tb/tb_nabp_mapper_addr_gen.sv
// Randomized and directed bench for nabp_mapper_addr_gen with a 2-cycle registered LUT model.
module tb_nabp_mapper_addr_gen;

   localparam int ANGLE_W = 8;
   localparam int INT_W   = 9;
   localparam int FRAC_W  = 12;
   localparam int IMG     = 8;
   localparam int LINE    = 8;
   localparam int AW      = 3;
   localparam int ACCU_W  = 1 + INT_W + FRAC_W;
   localparam int ONE     = 1 << FRAC_W;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic                     start = 1'b0;
   logic [ANGLE_W-1:0]       angle = '0;
   logic                     busy;
   logic                     done;
   logic [ANGLE_W-1:0]       mp_angle;
   logic signed [ACCU_W-1:0] mp_accu_part;
   logic signed [ACCU_W-1:0] mp_accu_base;
   logic [ANGLE_W-1:0]       lut_s1;
   logic signed [ACCU_W-1:0] lut_base [256];
   logic signed [ACCU_W-1:0] lut_part [256];

   int total = 0;
   int bad   = 0;

   nabp_mapper_addr_gen_if #(.ADDR_W(AW)) bus ();

   nabp_mapper_addr_gen #(
      .ANGLE_W     (ANGLE_W),
      .ACCU_INT_W  (INT_W),
      .ACCU_FRAC_W (FRAC_W),
      .IMAGE_SIZE  (IMG),
      .LINE_LEN    (LINE),
      .ADDR_W      (AW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .angle        (angle),
      .busy         (busy),
      .done         (done),
      .mp_angle     (mp_angle),
      .mp_accu_part (mp_accu_part),
      .mp_accu_base (mp_accu_base),
      .addr_bus     (bus)
   );

   always #5 clk = ~clk;

   // Coefficient LUT: angle registered, then table data registered.
   always @(posedge clk) begin
      lut_s1       <= mp_angle;
      mp_accu_base <= lut_base[lut_s1];
      mp_accu_part <= lut_part[lut_s1];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint floor_div(input longint a);
      if (a >= 0) return a / ONE;
      return -((-a + ONE - 1) / ONE);
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, bus.addr_valid, 0);
      check({tag, "_addr"}, bus.addr, 0);
      check({tag, "_oob"}, bus.addr_oob, 0);
      check({tag, "_last"}, bus.addr_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mp_angle"}, mp_angle, 0);
   endtask

   // poke: bit0 start pulse mid-RUN, bit1 start pulse in DONE, bit2 reset at step 3.
   task automatic run_op(input logic [ANGLE_W-1:0] ang, input int base, input int part,
                         input int mode, input int poke);
      int     k;
      int     cyc;
      int     lat;
      logic   rdy;
      longint acc;
      longint ip;
      logic   exp_oob;
      int     exp_addr;

      lut_base[ang] = ACCU_W'(base);
      lut_part[ang] = ACCU_W'(part);
      check("idle_busy", busy, 0);
      angle = ang;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      angle = ~ang;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) check("mp_angle_capture", mp_angle, ang);
         if (!bus.addr_valid) check("busy_wait", busy, 1);
      end while (!bus.addr_valid && lat < 20);
      check("start_latency", lat, 4);

      k = 0;
      cyc = 0;
      while (k < IMG && cyc < 200) begin
         acc      = longint'(base) + longint'(k) * longint'(part);
         ip       = floor_div(acc);
         exp_oob  = (acc < 0) || (ip >= LINE);
         exp_addr = exp_oob ? 0 : int'(ip);
         check("valid", bus.addr_valid, 1);
         check("addr", bus.addr, exp_addr);
         check("oob", bus.addr_oob, exp_oob);
         check("last", bus.addr_last, k == IMG - 1);
         check("busy_run", busy, 1);
         check("done_run", done, 0);
         if ((poke & 4) != 0 && k == 3) begin
            reset_n = 1'b0;
            #1;
            check_quiet("async_rst");
            bus.addr_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("rst_no_done", done, 0);
            end
            reset_n = 1'b1;
            @(negedge clk);
            check_quiet("after_rst");
            bus.addr_ready = 1'b0;
            return;
         end
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
         else rdy = 1'($urandom_range(0, 1));
         bus.addr_ready = rdy;
         if ((poke & 1) != 0 && cyc == 1) begin
            start = 1'b1;
            angle = ang + 8'd1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (rdy) begin
            $display("xfer angle=%0d step=%0d addr=%0d oob=%0d last=%0d",
                     ang, k, exp_addr, exp_oob, k == IMG - 1);
            k++;
         end
         cyc++;
         @(negedge clk);
         if ((poke & 1) != 0 && cyc == 2) check("angle_hold", mp_angle, ang);
      end
      check("xfer_budget", k, IMG);
      bus.addr_ready = 1'b0;
      check("done_valid", bus.addr_valid, 0);
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      if ((poke & 2) != 0) begin
         start = 1'b1;
         angle = ang + 8'd2;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_valid", bus.addr_valid, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         lut_base[i] = '0;
         lut_part[i] = '0;
      end
      bus.addr_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_quiet("idle");

      run_op(8'h11, 0, ONE, 0, 0);
      run_op(8'h22, 10240, 3072, 0, 0);
      run_op(8'h33, -6144, ONE, 0, 2);
      run_op(8'h44, 6 * ONE, ONE / 2, 0, 0);
      run_op(8'h55, 0, ONE, 1, 1);
      run_op(8'h66, 0, ONE, 0, 5);

      for (int r = 0; r < 8; r++) begin
         run_op(8'($urandom_range(0, 255)),
                int'($urandom_range(0, 14 * ONE)) - 4 * ONE,
                int'($urandom_range(0, 4 * ONE)) - 2 * ONE,
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
